uart_rx_ctrl: RTL and testbench

Receive-path controller between the UART RX shift register and the RX FIFO. It edge-detects the shift register's received-byte and break pulses, packs data and error flags into FIFO entries and sequences the FIFO write through a one-entry hold register. It also tracks overrun, frame-error count and receive timeout, and raises a level interrupt toward the host register block.

---
 rtl/uart_rx_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive-path controller between RX shift register and RX FIFO
//
// Purpose:
//   Edge-detects the shift register's byte-ready and break levels, packs
//   {break, frame_err, data} entries, and sequences FIFO writes through a
//   one-entry hold register. Tracks sticky overrun, a saturating frame-error
//   count and (optionally) a receive timeout, and drives a level interrupt.
//
// Configuration macro:
//   UART_RX_TIMEOUT_EN - when defined, a baud-tick counter raises the sticky
//                        timeout flag after TIMEOUT_TICKS ticks without a FIFO
//                        write while the FIFO is non-empty. When undefined,
//                        timeout is tied to 0.
//
// Parameters:
//   LEVEL_W        width of fifo_level and irq_thresh
//   TIMEOUT_TICKS  baud ticks without a write (FIFO non-empty) before timeout
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   enable          receiver enable; 0 idles the controller and clears hold
//   baud_tick       one-cycle pulse per bit time
//   rx_data         received byte from the shift register
//   rx_valid        byte-ready level (rising edge = new byte)
//   rx_frame_err    stop-bit error qualifying rx_data
//   rx_break_valid  break-detected level (rising edge = break event)
//   fifo_full       RX FIFO full
//   fifo_level      RX FIFO occupancy
//   fifo_wr         FIFO write strobe (combinational)
//   fifo_wdata      FIFO write data {break, frame_err, data[7:0]}
//   irq_thresh      FIFO level interrupt threshold, 0 disables
//   irq_clr         one-cycle clear of overrun, timeout and err_count
//   overrun         sticky: an event was dropped
//   timeout         sticky: receive timeout
//   err_count       saturating count of committed frame-error entries
//   irq             level interrupt

module uart_rx_ctrl #(
  parameter int LEVEL_W       = 5,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               baud_tick,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rx_frame_err,
  input  logic               rx_break_valid,
  input  logic               fifo_full,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_wr,
  output logic [9:0]         fifo_wdata,
  input  logic [LEVEL_W-1:0] irq_thresh,
  input  logic               irq_clr,
  output logic               overrun,
  output logic               timeout,
  output logic [7:0]         err_count,
  output logic               irq
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t     state;
  logic [9:0] hold;
  logic       valid_q;
  logic       brk_q;

  logic       data_ev;
  logic       brk_ev;
  logic       ev;
  logic [9:0] entry;
  logic       commit;
  logic       ovr_set;
  logic       err_inc;

  // Rising-edge detection on the level inputs; events are only honoured
  // while enabled, but the edge registers always track the inputs so that a
  // level already high when enable rises does not produce a stale event.
  assign data_ev = rx_valid & ~valid_q;
  assign brk_ev  = rx_break_valid & ~brk_q;
  assign ev      = enable & (data_ev | brk_ev);

  always_comb begin
    entry = 10'h000;
    if (data_ev) begin
      entry = {brk_ev, rx_frame_err, rx_data};
    end else if (brk_ev) begin
      entry = 10'h200;
    end
  end

  assign fifo_wr    = enable & (state == PEND) & ~fifo_full;
  assign fifo_wdata = hold;
  assign commit     = fifo_wr;

  // An event that arrives while the hold register cannot drain is dropped.
  assign ovr_set = ev & (state == PEND) & ~commit;
  assign err_inc = commit & hold[8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
      state   <= IDLE;
      hold    <= 10'h000;
    end else begin
      valid_q <= rx_valid;
      brk_q   <= rx_break_valid;
      if (!enable) begin
        state <= IDLE;
        hold  <= 10'h000;
      end else begin
        case (state)
          IDLE: begin
            if (ev) begin
              hold  <= entry;
              state <= PEND;
            end
          end
          PEND: begin
            if (commit) begin
              // Draining and refilling in the same cycle keeps one entry per
              // cycle throughput without flagging overrun.
              if (ev) begin
                hold <= entry;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: begin
            state <= IDLE;
            hold  <= 10'h000;
          end
        endcase
      end
    end
  end

  // Sticky status: a set/increment in the same cycle as irq_clr takes effect
  // after the clear, so the new condition is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (irq_clr) begin
        overrun <= 1'b0;
      end

      if (irq_clr) begin
        err_count <= err_inc ? 8'h01 : 8'h00;
      end else if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'h01;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] TICKS_MAX = CNT_W'(TIMEOUT_TICKS);

  logic [CNT_W-1:0] to_cnt;
  logic             to_clear;
  logic             to_set;

  assign to_clear = commit | (fifo_level == '0) | ~enable;
  // Timeout fires only on the transition into the terminal count; the counter
  // then parks there, so a cleared flag needs a fresh full count to re-arm.
  assign to_set   = ~to_clear & baud_tick & (to_cnt == TICKS_MAX - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (to_clear) begin
        to_cnt <= '0;
      end else if (baud_tick && (to_cnt != TICKS_MAX)) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (to_set) begin
        timeout <= 1'b1;
      end else if (irq_clr) begin
        timeout <= 1'b0;
      end
    end
  end
`else
  logic unused_baud_tick;
  assign unused_baud_tick = baud_tick;
  assign timeout          = 1'b0;
`endif

  assign irq = overrun | timeout | (err_count != 8'h00) |
               ((irq_thresh != '0) & (fifo_level >= irq_thresh));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       baud_tick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_break_valid;
  logic       fifo_full;
  logic [4:0] fifo_level;
  logic       fifo_wr;
  logic [9:0] fifo_wdata;
  logic [4:0] irq_thresh;
  logic       irq_clr;
  logic       overrun;
  logic       timeout;
  logic [7:0] err_count;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [9:0] wq[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.LEVEL_W(5), .TIMEOUT_TICKS(40)) dut (
    .clk(clk), .rst(rst), .enable(enable), .baud_tick(baud_tick),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .rx_break_valid(rx_break_valid), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .irq_thresh(irq_thresh), .irq_clr(irq_clr), .overrun(overrun),
    .timeout(timeout), .err_count(err_count), .irq(irq)
  );

  // Write monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (fifo_wr === 1'b1) begin
      wr_cnt++;
      wq.push_back(fifo_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic fe);
    rx_data = d; rx_frame_err = fe; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      baud_tick = 1'b1;
      tick();
      baud_tick = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_clr();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; baud_tick = 0; rx_data = 0; rx_valid = 0;
    rx_frame_err = 0; rx_break_valid = 0; fifo_full = 0; fifo_level = 0;
    irq_thresh = 0; irq_clr = 0;
    tick(); tick();
    n_checks++;
    if ({fifo_wr, fifo_wdata, overrun, timeout, err_count, irq} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr=%b wdata=%h ovr=%b to=%b err=%0d irq=%b expected all 0",
               fifo_wr, fifo_wdata, overrun, timeout, err_count, irq);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    int w0;
    w0 = wr_cnt; wq.delete();
    rx_data = 8'hA5; rx_frame_err = 0; rx_valid = 1'b1;
    tick();
    n_checks++;
    if (fifo_wr !== 1'b1 || fifo_wdata !== 10'h0A5) begin
      n_fail++;
      $display("FAIL single_latency: got wr=%b wdata=%h expected wr=1 wdata=0a5", fifo_wr, fifo_wdata);
    end
    for (int i = 0; i < 15; i++) tick();
    rx_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_cnt - w0 !== 1 || wq.size() != 1 || wq[0] !== 10'h0A5) begin
      n_fail++;
      $display("FAIL single_count: got %0d writes expected 1 of 0a5", wr_cnt - w0);
    end
  endtask

  task automatic test_overrun();
    int w0;
    w0 = wr_cnt; wq.delete();
    fifo_full = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    n_checks++;
    if (wr_cnt - w0 !== 0 || overrun !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got writes=%0d ovr=%b irq=%b expected 0 1 1", wr_cnt - w0, overrun, irq);
    end
    fifo_full = 1'b0;
    tick(); tick();
    n_checks++;
    if (wr_cnt - w0 !== 1 || wq.size() != 1 || wq[0] !== 10'h011) begin
      n_fail++;
      $display("FAIL overrun_drain: got writes=%0d expected 1 of 011", wr_cnt - w0);
    end
    pulse_clr();
    n_checks++;
    if (overrun !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clr: got ovr=%b irq=%b expected 0 0", overrun, irq);
    end
  endtask

  task automatic test_flags();
    wq.delete();
    rx_break_valid = 1'b1;
    tick(); tick(); tick();
    rx_break_valid = 1'b0;
    tick();
    n_checks++;
    if (wq.size() != 1 || wq[0] !== 10'h200) begin
      n_fail++;
      $display("FAIL break_entry: got %0d entries first=%h expected 1 of 200", wq.size(), (wq.size() > 0) ? wq[0] : 10'h3FF);
    end
    wq.delete();
    send_byte(8'h3C, 1'b1);
    n_checks++;
    if (wq.size() != 1 || wq[0] !== 10'h13C || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL frame_err_entry: got entries=%0d err=%0d expected 13c and err 1", wq.size(), err_count);
    end
    // Merged break + data entry in the same cycle.
    wq.delete();
    rx_data = 8'h5A; rx_frame_err = 1'b0; rx_valid = 1'b1; rx_break_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_break_valid = 1'b0;
    tick();
    n_checks++;
    if (wq.size() != 1 || wq[0] !== 10'h25A) begin
      n_fail++;
      $display("FAIL merged_entry: got entries=%0d expected 1 of 25a", wq.size());
    end
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
    n_checks++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d expected 255", err_count);
    end
    // Clear coinciding with an increment: increment wins, count restarts at 1.
    rx_data = 8'h01; rx_frame_err = 1'b1; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL err_clr_collide: got %0d expected 1", err_count);
    end
    pulse_clr();
    n_checks++;
    if (err_count !== 8'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: got err=%0d irq=%b expected 0 0", err_count, irq);
    end
    rx_frame_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    wq.delete();
    rx_data = 8'h77; rx_valid = 1'b1;
    tick();
    rx_break_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_break_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (wq.size() != 2 || wq[0] !== 10'h077 || wq[1] !== 10'h200 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: got entries=%0d ovr=%b expected 077,200 ovr 0", wq.size(), overrun);
    end
  endtask

  task automatic test_enable();
    int w0;
    w0 = wr_cnt;
    fifo_full = 1'b1;
    send_byte(8'h44, 1'b0);
    enable = 1'b0;
    #1;
    n_checks++;
    if (fifo_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_wr_gate: got wr=%b expected 0", fifo_wr);
    end
    tick();
    fifo_full = 1'b0;
    rx_data = 8'h55; rx_valid = 1'b1;
    tick(); tick();
    enable = 1'b1;
    tick(); tick(); tick();
    rx_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL enable_hold_cleared: got writes=%0d expected 0", wr_cnt - w0);
    end
  endtask

  task automatic test_timeout();
    fifo_level = 5'd1;
`ifdef UART_RX_TIMEOUT_EN
    send_ticks(30);
    send_byte(8'h66, 1'b0);
    send_ticks(39);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_39: got %b expected 0", timeout);
    end
    send_ticks(1);
    n_checks++;
    if (timeout !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_40: got to=%b irq=%b expected 1 1", timeout, irq);
    end
    pulse_clr();
    send_ticks(45);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_rearm: got %b expected 0", timeout);
    end
    fifo_level = 5'd0;
    tick();
    fifo_level = 5'd1;
    send_ticks(40);
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fresh: got %b expected 1", timeout);
    end
    pulse_clr();
`else
    send_ticks(50);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_disabled: got %b expected 0", timeout);
    end
`endif
    fifo_level = 5'd0;
    tick();
  endtask

  task automatic test_threshold();
    irq_thresh = 5'd4; fifo_level = 5'd3;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL thresh_below: got %b expected 0", irq);
    end
    fifo_level = 5'd4;
    #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL thresh_equal: got %b expected 1", irq);
    end
    irq_thresh = 5'd0; fifo_level = 5'd31;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL thresh_disabled: got %b expected 0", irq);
    end
    fifo_level = 5'd0;
    tick();
  endtask

  task automatic test_reset_mid_pend();
    int w0;
    fifo_full = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({fifo_wr, fifo_wdata, overrun, timeout, err_count, irq} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_async: got wr=%b wdata=%h ovr=%b to=%b err=%0d irq=%b expected all 0",
               fifo_wr, fifo_wdata, overrun, timeout, err_count, irq);
    end
    #3;
    rst = 1'b0;
    fifo_full = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL reset_hold_empty: got writes=%0d expected 0", wr_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overrun();
    test_flags();
    test_back_to_back();
    test_enable();
    test_timeout();
    test_threshold();
    test_reset_mid_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
